// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text buffer and its RAM.
package text_pkg;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/text_ram.sv
// Character store: one synchronous write port, one registered read port.
// Reads beyond DEPTH return a space; read-during-write returns the old cell.
module text_ram
  import text_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdat,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdat
);

  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] rd_q;
  logic       in_range_s;

  generate
    if (DEPTH < (1 << ADDR_W)) begin : g_partial
      assign in_range_s = ({1'b0, i_raddr} < (ADDR_W+1)'(DEPTH));
    end else begin : g_full
      assign in_range_s = 1'b1;
    end
  endgenerate

  // Storage array is deliberately not reset; the owner clears it by writing.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdat;
    end
  end

  // Registered read output.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q <= ASCII_SPACE;
    end else if (in_range_s) begin
      rd_q <= mem[i_raddr];
    end else begin
      rd_q <= ASCII_SPACE;
    end
  end

  assign o_rdat = rd_q;

endmodule

// File: rtl/text_buffer.sv
// ROWS x COLS character grid with cursor, fed by key events and read by a display driver.
// After reset or i_sclr the grid is filled with spaces before events are accepted.
module text_buffer
  import text_pkg::*;
#(
  parameter  int COLS   = 16,
  parameter  int ROWS   = 2,
  localparam int ADDR_W = $clog2(ROWS*COLS),
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W  = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_sclr,
  input  logic [7:0]        i_ascii,
  input  logic              i_ascii_en,
  input  logic              i_right_en,
  input  logic              i_down_en,
  input  logic              i_left_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_dat,
  output logic [ROW_W-1:0]  o_cur_row,
  output logic [COL_W-1:0]  o_cur_col,
  output logic              o_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS*COLS-1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS-1);

  state_e             state_q;
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               ready_q;

  logic [ROW_W-1:0]   adv_row_s, ret_row_s, dn_row_s;
  logic [COL_W-1:0]   adv_col_s, ret_col_s;
  logic [ADDR_W-1:0]  cur_addr_s, ret_addr_s;
  logic               we_s;
  logic [ADDR_W-1:0]  waddr_s;
  logic [7:0]         wdat_s;

  // Candidate cursor positions: one cell forward, one cell back, one row down.
  always_comb begin
    adv_row_s = row_q;
    adv_col_s = col_q + COL_W'(1);
    if (col_q == LAST_COL) begin
      adv_col_s = '0;
      if (row_q == LAST_ROW) begin
        adv_row_s = '0;
      end else begin
        adv_row_s = row_q + ROW_W'(1);
      end
    end else begin
      adv_row_s = row_q;
    end

    ret_row_s = row_q;
    ret_col_s = col_q;
    if (col_q != '0) begin
      ret_col_s = col_q - COL_W'(1);
    end else if (row_q != '0) begin
      ret_col_s = LAST_COL;
      ret_row_s = row_q - ROW_W'(1);
    end else begin
      ret_col_s = col_q;
    end

    if (row_q == LAST_ROW) begin
      dn_row_s = '0;
    end else begin
      dn_row_s = row_q + ROW_W'(1);
    end

    cur_addr_s = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
    ret_addr_s = ADDR_W'(ret_row_s) * ADDR_W'(COLS) + ADDR_W'(ret_col_s);
  end

  // Event decode: RAM write port and next cursor, highest-priority strobe wins.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    we_s    = 1'b0;
    waddr_s = cur_addr_s;
    wdat_s  = ASCII_SPACE;
    if (state_q == ST_CLEAR) begin
      we_s    = 1'b1;
      waddr_s = clr_cnt_q;
      wdat_s  = ASCII_SPACE;
    end else if (i_sclr) begin
      we_s = 1'b0;
    end else if (i_ascii_en) begin
      we_s = 1'b1;
      if (i_ascii == ASCII_BS) begin
        row_d   = ret_row_s;
        col_d   = ret_col_s;
        waddr_s = ret_addr_s;
        wdat_s  = ASCII_SPACE;
      end else begin
        row_d   = adv_row_s;
        col_d   = adv_col_s;
        waddr_s = cur_addr_s;
        wdat_s  = i_ascii;
      end
    end else if (i_right_en) begin
      row_d = adv_row_s;
      col_d = adv_col_s;
    end else if (i_down_en) begin
      row_d = dn_row_s;
    end else if (i_left_en) begin
      row_d = ret_row_s;
      col_d = ret_col_s;
    end else begin
      we_s = 1'b0;
    end
  end

  // Control FSM: clear sweep, then idle event processing.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ready_q   <= 1'b0;
    end else if (i_sclr) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            ready_q   <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            ready_q   <= 1'b0;
          end
        end
        ST_IDLE: begin
          row_q   <= row_d;
          col_q   <= col_d;
          ready_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  text_ram #(
    .DEPTH  (ROWS*COLS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_we    (we_s),
    .i_waddr (waddr_s),
    .i_wdat  (wdat_s),
    .i_raddr (i_rd_addr),
    .o_rdat  (o_rd_dat)
  );

  assign o_cur_row = row_q;
  assign o_cur_col = col_q;
  assign o_ready   = ready_q;

endmodule

// File: tb/tb_text_buffer.sv
// Randomized bench for text_buffer against a linear-position reference model.
module tb_text_buffer;
  import text_pkg::*;

  localparam int COLS = 16;
  localparam int ROWS = 2;
  localparam int N    = ROWS*COLS;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_sclr;
  logic [7:0] i_ascii;
  logic       i_ascii_en, i_right_en, i_down_en, i_left_en;
  logic [4:0] i_rd_addr;
  logic [7:0] o_rd_dat;
  logic [0:0] o_cur_row;
  logic [3:0] o_cur_col;
  logic       o_ready;

  always #5 clk = ~clk;

  text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_sclr     (i_sclr),
    .i_ascii    (i_ascii),
    .i_ascii_en (i_ascii_en),
    .i_right_en (i_right_en),
    .i_down_en  (i_down_en),
    .i_left_en  (i_left_en),
    .i_rd_addr  (i_rd_addr),
    .o_rd_dat   (o_rd_dat),
    .o_cur_row  (o_cur_row),
    .o_cur_col  (o_cur_col),
    .o_ready    (o_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl_mem [N];
  int mdl_pos;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cursor(input string tag);
    check_eq({tag, "_row"}, 32'(o_cur_row), 32'(mdl_pos / COLS));
    check_eq({tag, "_col"}, 32'(o_cur_col), 32'(mdl_pos % COLS));
  endtask

  task automatic clear_model();
    for (int a = 0; a < N; a++) mdl_mem[a] = 8'h20;
    mdl_pos = 0;
  endtask

  task automatic drop_strobes();
    i_ascii_en = 1'b0;
    i_right_en = 1'b0;
    i_down_en  = 1'b0;
    i_left_en  = 1'b0;
  endtask

  // One IDLE cycle: apply strobes, check cursor and a random read of pre-edge contents.
  task automatic event_cycle(input string tag, input logic a_en, input logic [7:0] ch,
                             input logic r, input logic d, input logic l);
    int ra;
    logic [7:0] exp_rd;
    ra = int'($urandom_range(0, N-1));
    i_rd_addr = 5'(ra);
    exp_rd = mdl_mem[ra];
    i_ascii_en = a_en; i_ascii = ch; i_right_en = r; i_down_en = d; i_left_en = l;
    @(posedge clk); #1;
    drop_strobes();
    if (a_en) begin
      if (ch == 8'h08) begin
        if (mdl_pos > 0) mdl_pos--;
        mdl_mem[mdl_pos] = 8'h20;
      end else begin
        mdl_mem[mdl_pos] = ch;
        mdl_pos = (mdl_pos + 1) % N;
      end
    end else if (r) begin
      mdl_pos = (mdl_pos + 1) % N;
    end else if (d) begin
      mdl_pos = (((mdl_pos / COLS) + 1) % ROWS) * COLS + (mdl_pos % COLS);
    end else if (l) begin
      if (mdl_pos > 0) mdl_pos--;
    end
    check_eq({tag, "_rd"}, 32'(o_rd_dat), 32'(exp_rd));
    check_cursor(tag);
  endtask

  task automatic goto_cell(input int row, input int col);
    for (int k = 0; k < N && mdl_pos != row*COLS + col; k++)
      event_cycle("goto", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic noise_strobes();
    i_ascii    = 8'($urandom_range(8, 126));
    i_ascii_en = ($urandom_range(0, 1) == 0);
    i_right_en = ($urandom_range(0, 1) == 0);
    i_down_en  = ($urandom_range(0, 1) == 0);
    i_left_en  = ($urandom_range(0, 1) == 0);
  endtask

  // Clear sweep in progress: random strobes must have no effect.
  task automatic noise_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      noise_strobes();
      @(posedge clk); #1;
      drop_strobes();
      check_eq("clr_ready", 32'(o_ready), 32'd0);
      check_eq("clr_col", 32'(o_cur_col), 32'd0);
    end
  endtask

  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    while (cnt < 200) begin
      noise_strobes();
      @(posedge clk); #1;
      drop_strobes();
      cnt++;
      if (o_ready) break;
    end
    check_eq({tag, "_cycles"}, 32'(cnt), 32'(N));
    clear_model();
    check_cursor(tag);
  endtask

  task automatic do_sclr();
    i_sclr = 1'b1;
    @(posedge clk); #1;
    i_sclr = 1'b0;
    check_eq("sclr_ready", 32'(o_ready), 32'd0);
    check_eq("sclr_row", 32'(o_cur_row), 32'd0);
    check_eq("sclr_col", 32'(o_cur_col), 32'd0);
  endtask

  task automatic check_all_mem(input string tag);
    for (int a = 0; a < N; a++) begin
      i_rd_addr = 5'(a);
      @(posedge clk); #1;
      check_eq(tag, 32'(o_rd_dat), 32'(mdl_mem[a]));
    end
  endtask

  initial begin
    logic [7:0] ch;
    i_rst_n = 1'b0; i_sclr = 1'b0; i_ascii = 8'h00; i_rd_addr = 5'd0;
    drop_strobes();
    clear_model();
    #12;
    check_eq("rst_ready", 32'(o_ready), 32'd0);
    check_eq("rst_rd", 32'(o_rd_dat), 32'h20);
    check_cursor("rst");
    @(negedge clk) i_rst_n = 1'b1;
    wait_clear("init");
    check_all_mem("init_mem");

    for (int k = 0; k < 3; k++) event_cycle("charA", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    check_eq("tp_col3", 32'(o_cur_col), 32'd3);
    goto_cell(0, 15);
    event_cycle("wrapB", 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    goto_cell(1, 15);
    event_cycle("wrapC", 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    check_eq("tp_wrap_col", 32'(o_cur_col), 32'd0);
    goto_cell(1, 0);
    event_cycle("bs_row", 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    goto_cell(0, 0);
    event_cycle("bs_home", 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    event_cycle("left_home", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    goto_cell(0, 5);
    event_cycle("prio", 1'b1, 8'h41, 1'b1, 1'b0, 1'b1);
    event_cycle("prio_rd", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    goto_cell(1, 7);
    event_cycle("down", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_all_mem("dir_mem");

    for (int k = 0; k < 400; k++) begin
      ch = ($urandom_range(0, 4) == 0) ? 8'h08 : 8'($urandom_range(33, 126));
      event_cycle("rand", ($urandom_range(0, 2) == 0), ch, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    check_all_mem("rand_mem");

    do_sclr();
    noise_cycles(9);
    do_sclr();
    wait_clear("sclr");
    check_all_mem("sclr_mem");

    for (int k = 0; k < 20; k++)
      event_cycle("pre_rst", 1'b1, 8'($urandom_range(33, 126)), 1'b0, 1'b0, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(o_ready), 32'd0);
    check_eq("mid_rst_rd", 32'(o_rd_dat), 32'h20);
    check_eq("mid_rst_col", 32'(o_cur_col), 32'd0);
    @(negedge clk) i_rst_n = 1'b1;
    wait_clear("rst2");
    check_all_mem("rst2_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Consumer end of the key-event interface: accepts one-cycle ASCII events (character / backspace) and cursor-move events (right / down / left).
- Maintains a ROWS x COLS character grid plus a cursor.
- Exposes a registered read port for the display driver, and the cursor position for cursor rendering.
- Sits between the key input stage and the character display (16x2 LCD by default).

Parameters:
- COLS, 16, characters per row (>= 2).
- ROWS, 2, number of rows (>= 1).
- ADDR_W, $clog2(ROWS*COLS), linear cell address width (derived; do not override).

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_sclr  in  1  synchronous clear: re-enter CLEAR, cursor to (0,0)
- i_ascii  in  8  ASCII code; 8'h08 = backspace, any other value = printable char
- i_ascii_en  in  1  one-cycle strobe qualifying i_ascii
- i_right_en  in  1  one-cycle cursor-right strobe
- i_down_en  in  1  one-cycle cursor-down strobe
- i_left_en  in  1  one-cycle cursor-left strobe
- i_rd_addr  in  ADDR_W  display read address (row*COLS + col)
- o_rd_dat  out  8  character at i_rd_addr, 1-cycle latency
- o_cur_row  out  $clog2(ROWS) (min 1)  cursor row
- o_cur_col  out  $clog2(COLS)  cursor column
- o_ready  out  1  high when IDLE (events accepted)

Behaviour:
- Reset (i_rst_n low, async):
  - state = CLEAR, clear counter = 0, cursor = (0,0).
  - o_rd_dat = 8'h20, o_ready = 0.
  - Buffer RAM is not reset directly; CLEAR fills it.
- States: CLEAR, IDLE.
  - CLEAR: writes 8'h20 to address = clear counter, one cell per cycle. Counter increments each cycle. After writing address ROWS*COLS-1, go to IDLE. Total ROWS*COLS cycles. All input events ignored and dropped; o_ready = 0.
  - IDLE: o_ready = 1. Processes at most one event per cycle.
- Event priority when strobes coincide: i_ascii_en > i_right_en > i_down_en > i_left_en. Lower-priority strobes that cycle are dropped, not queued.
- Printable char (i_ascii_en, i_ascii != 8'h08):
  - Write i_ascii at the cursor cell, then advance the cursor.
  - col+1; at col COLS-1, go to col 0, row+1. At the last cell, wrap to (0,0).
- Backspace (i_ascii_en, i_ascii == 8'h08):
  - Move the cursor back one cell: col-1; at col 0, go to col COLS-1, row-1.
  - Write 8'h20 at the new cursor cell in the same cycle.
  - At (0,0): cursor stays, cell (0,0) is written 8'h20.
- Right: same advance rule as a printable char, no write.
- Left: same retreat rule as backspace, no write. At (0,0) it stays.
- Down: row = (row+1) mod ROWS; col unchanged.
- Cursor update is registered: the new o_cur_row / o_cur_col are visible the cycle after the strobe.
- A write is visible on o_rd_dat for a read issued the cycle after the write cycle.
- Read port:
  - o_rd_dat <= mem[i_rd_addr] every clock, in all states; same-cycle read-during-write returns old data.
  - During CLEAR, reads return a mix of old and cleared data.
  - i_rd_addr >= ROWS*COLS returns 8'h20.
- i_sclr: synchronous; takes priority over events. Next cycle: state = CLEAR, counter = 0, cursor = (0,0). Asserting i_sclr mid-CLEAR restarts the clear from address 0.
- Reset mid-operation: async abort to the reset values above. Partially written data is overwritten by the subsequent CLEAR.
- All cursor arithmetic is explicit compare-and-wrap; no reliance on power-of-two sizes.

Decomposition:
- Shared package/header text_pkg holds constants: ASCII_BS = 8'h08, ASCII_SPACE = 8'h20; state encoding CLEAR/IDLE.
- One natural sub-module: text_ram, a single-port-write / single-port-read synchronous RAM, 8 x (ROWS*COLS), registered read output.
- Cursor logic and FSM stay in text_buffer.

Test Plan:
- Reset release -> o_ready = 0 for exactly 32 cycles (16x2), then 1. Every address 0..31 reads 8'h20.
- In IDLE, send 'A' (8'h41) x3 -> cursor (0,3). Read addr 0,1,2 = 8'h41; addr 3 = 8'h20.
- Cursor at (0,15), send 'B' -> mem[15] = 8'h42, cursor (1,0). At (1,15), send 'C' -> mem[31] = 8'h43, cursor (0,0).
- Backspace at (1,0) -> cursor (0,15), mem[15] = 8'h20. Backspace at (0,0) -> cursor stays (0,0), mem[0] = 8'h20.
- Same cycle i_ascii_en = 1 ('A') and i_right_en = 1 and i_left_en = 1 at (0,5) -> only the char is applied: mem[5] = 8'h41, cursor (0,6). Down at (1,7) -> cursor (0,7).
- i_sclr pulsed mid-CLEAR at counter 10, and separately i_rst_n low mid-IDLE -> clear restarts at 0, takes the full 32 cycles, cursor (0,0). Events during CLEAR produce no writes.
